// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - op codes, FSM states and lane helpers for the MEM-stage access unit
package mem_access_unit_pkg;

    localparam int MAU_ALUOP_W = 8;
    localparam int MAU_DW      = 32;

    localparam logic [MAU_ALUOP_W-1:0] EXE_NOP_OP = 8'h00;
    localparam logic [MAU_ALUOP_W-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [MAU_ALUOP_W-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [MAU_ALUOP_W-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [MAU_ALUOP_W-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [MAU_ALUOP_W-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [MAU_ALUOP_W-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [MAU_ALUOP_W-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [MAU_ALUOP_W-1:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_WAIT = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_t;

    function automatic logic is_load_op(input logic [MAU_ALUOP_W-1:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [MAU_ALUOP_W-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one
    function automatic logic is_misaligned(input logic [MAU_ALUOP_W-1:0] op, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) bad = a[0];
        else if (op inside {EXE_LW_OP, EXE_SW_OP})       bad = (a != 2'b00);
        return bad;
    endfunction

    // Big-endian lanes: address offset 0 is the most significant byte
    function automatic logic [3:0] lane_sel(input logic [MAU_ALUOP_W-1:0] op, input logic [1:0] a);
        logic [3:0] sel;
        sel = 4'b1111;
        if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP})      sel = 4'b1000 >> a;
        else if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) sel = a[1] ? 4'b0011 : 4'b1100;
        return sel;
    endfunction

    // Store data is replicated so the slave can pick whichever lane sel enables
    function automatic logic [MAU_DW-1:0] store_data(input logic [MAU_ALUOP_W-1:0] op, input logic [MAU_DW-1:0] reg2);
        logic [MAU_DW-1:0] d;
        d = '0;
        case (op)
            EXE_SB_OP: d = {4{reg2[7:0]}};
            EXE_SH_OP: d = {2{reg2[15:0]}};
            EXE_SW_OP: d = reg2;
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// rtl/mem_access_unit_load_extract.sv - picks and extends byte/half/word load data from a bus word
module load_extract
    import mem_access_unit_pkg::*;
#(
    parameter int ALUOP_W = MAU_ALUOP_W,
    parameter int DW      = MAU_DW
) (
    input  logic [ALUOP_W-1:0] op,
    input  logic [1:0]         a,
    input  logic [DW-1:0]      word,
    output logic [DW-1:0]      result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select by offset, then sign/zero extend according to the op
    always_comb begin
        case (a)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        half_v = a[1] ? word[15:0] : word[31:16];
        case (op)
            EXE_LB_OP:  result = {{(DW-8){byte_v[7]}}, byte_v};
            EXE_LBU_OP: result = {{(DW-8){1'b0}}, byte_v};
            EXE_LH_OP:  result = {{(DW-16){half_v[15]}}, half_v};
            EXE_LHU_OP: result = {{(DW-16){1'b0}}, half_v};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer on a req/ack data bus
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ALUOP_W = MAU_ALUOP_W,
    parameter int DW      = MAU_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic [ALUOP_W-1:0] mem_aluOp,
    input  logic [DW-1:0]      mem_addr,
    input  logic [DW-1:0]      mem_reg2,
    input  logic [4:0]         mem_wd,
    input  logic               mem_wreg,
    input  logic [DW-1:0]      mem_wdata,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [DW-1:0]      wb_wdata,
    output logic               stallreq,
    output logic               addr_misalign,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [DW-1:0]      dbus_addr,
    output logic [3:0]         dbus_sel,
    output logic [DW-1:0]      dbus_wdata,
    input  logic               dbus_ack,
    input  logic [DW-1:0]      dbus_rdata
);

    mau_state_t    state, next_state;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] load_data;
    logic          mem_op, misaligned, issue;
    logic          misalign_held;
    logic          stall_unused;

    assign stall_unused = ^{stall[5], stall[3:0]};
    assign mem_op       = is_load_op(mem_aluOp) || is_store_op(mem_aluOp);
    assign misaligned   = mem_op && is_misaligned(mem_aluOp, mem_addr[1:0]);
    assign issue        = mem_op && !misaligned;

    load_extract #(.ALUOP_W(ALUOP_W), .DW(DW)) u_load_extract (
        .op     (mem_aluOp),
        .a      (mem_addr[1:0]),
        .word   (rdata_q),
        .result (load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= MAU_IDLE;
        else     state <= next_state;
    end

    // Next state: one access at a time, DONE waits out any external hold so the op is never reissued
    always_comb begin
        next_state = state;
        case (state)
            MAU_IDLE: if (issue)     next_state = MAU_WAIT;
            MAU_WAIT: if (dbus_ack)  next_state = MAU_DONE;
            MAU_DONE: if (!stall[4]) next_state = MAU_IDLE;
            default:                 next_state = MAU_IDLE;
        endcase
    end

    // Outputs: stall while the access is pending, substitute load data once it has returned
    always_comb begin
        stallreq = 1'b0;
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        if (!rst) begin
            case (state)
                MAU_IDLE: begin
                    if (misaligned) begin
                        wb_wreg = 1'b0;
                    end else if (issue) begin
                        stallreq = 1'b1;
                        wb_wreg  = 1'b0;
                    end
                end
                MAU_WAIT: begin
                    stallreq = 1'b1;
                    wb_wreg  = 1'b0;
                end
                MAU_DONE: begin
                    if (is_store_op(mem_aluOp))     wb_wreg  = 1'b0;
                    else if (is_load_op(mem_aluOp)) wb_wdata = load_data;
                end
                default: stallreq = 1'b0;
            endcase
        end
    end

    // Bus request registers, load capture and the single-shot misalignment pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req      <= 1'b0;
            dbus_we       <= 1'b0;
            dbus_addr     <= '0;
            dbus_sel      <= '0;
            dbus_wdata    <= '0;
            rdata_q       <= '0;
            misalign_held <= 1'b0;
            addr_misalign <= 1'b0;
        end else begin
            addr_misalign <= misaligned && !misalign_held;
            misalign_held <= misaligned && stall[4];
            if (state == MAU_IDLE && issue) begin
                dbus_req   <= 1'b1;
                dbus_we    <= is_store_op(mem_aluOp);
                dbus_addr  <= {mem_addr[DW-1:2], 2'b00};
                dbus_sel   <= lane_sel(mem_aluOp, mem_addr[1:0]);
                dbus_wdata <= store_data(mem_aluOp, mem_reg2);
            end else if (state == MAU_WAIT && dbus_ack) begin
                dbus_req <= 1'b0;
                rdata_q  <= dbus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk, rst;
    logic [5:0]  stall;
    logic [7:0]  mem_aluOp;
    logic [31:0] mem_addr, mem_reg2, mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq, addr_misalign;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_sel;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .mem_aluOp(mem_aluOp), .mem_addr(mem_addr),
        .mem_reg2(mem_reg2), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
        .addr_misalign(addr_misalign), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected values for the current cycle, set by the stimulus after each drive
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_mis;
    logic        chk_bus, chk_sel, chk_bwd, chk_wb, chk_wbdata;
    logic        e_we;
    logic [31:0] e_addr, e_bwd, e_wbdata;
    logic [3:0]  e_sel;
    logic [4:0]  e_wd;
    logic        e_wreg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Compare every cycle at the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("stallreq", {31'd0, stallreq}, {31'd0, exp_stall});
            check("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
            check("addr_misalign", {31'd0, addr_misalign}, {31'd0, exp_mis});
            if (chk_bus) begin
                check("dbus_we", {31'd0, dbus_we}, {31'd0, e_we});
                check("dbus_addr", dbus_addr, e_addr);
                if (chk_sel) check("dbus_sel", {28'd0, dbus_sel}, {28'd0, e_sel});
                if (chk_bwd) check("dbus_wdata", dbus_wdata, e_bwd);
            end
            if (chk_wb) begin
                check("wb_wd", {27'd0, wb_wd}, {27'd0, e_wd});
                check("wb_wreg", {31'd0, wb_wreg}, {31'd0, e_wreg});
                if (chk_wbdata) check("wb_wdata", wb_wdata, e_wbdata);
            end
        end
    end

    // Reference rules written as plain arithmetic on the big-endian word
    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (op == EXE_LB_OP || op == EXE_LBU_OP) begin
            v = (w >> (8 * (3 - int'(a)))) & 32'hFF;
            if (op == EXE_LB_OP && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op == EXE_LH_OP || op == EXE_LHU_OP) begin
            v = (w >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
            if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [1:0] a);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 4'(1 << (3 - int'(a)));
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 4'(3 << (2 - 2 * int'(a[1])));
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] r);
        if (op == EXE_SB_OP) return (r & 32'hFF) * 32'h0101_0101;
        if (op == EXE_SH_OP) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic is_ld(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_stall = 0; exp_req = 0; exp_mis = 0;
        chk_bus = 0; chk_sel = 0; chk_bwd = 0; chk_wb = 0; chk_wbdata = 0;
    endtask

    // One non-memory cycle; a stray ack is driven to show it is ignored
    task automatic nonmem(input logic [7:0] op, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata, input logic ack);
        mem_aluOp = op; mem_addr = 32'h0000_0101; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        stall = 6'd0; dbus_ack = ack; dbus_rdata = $urandom;
        clear_exp();
        chk_wb = 1; chk_wbdata = 1; e_wd = wd; e_wreg = wreg; e_wbdata = wdata;
        tick();
        dbus_ack = 1'b0;
    endtask

    // Full access: ack arrives on the (wt+1)-th cycle req is high, then DONE held for 'hold' cycles
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int wt, input int hold,
                          input logic [3:0] x_sel, input logic [31:0] x_bwd, input logic [31:0] x_wb);
        logic ld;
        ld = is_ld(op);
        mem_aluOp = op; mem_addr = addr; mem_reg2 = reg2; mem_wd = 5'd7; mem_wreg = 1'b1;
        mem_wdata = 32'h5555_0000; stall = 6'd0; dbus_ack = 1'b0; dbus_rdata = $urandom;
        clear_exp();
        exp_stall = 1;
        tick();
        for (int i = 0; i <= wt; i++) begin
            exp_req = 1; chk_bus = 1; e_we = !ld; e_addr = {addr[31:2], 2'b00};
            chk_sel = !(ld && op != EXE_LW_OP); e_sel = x_sel;
            chk_bwd = !ld; e_bwd = x_bwd;
            dbus_ack = (i == wt);
            dbus_rdata = (i == wt) ? rdata : $urandom;
            tick();
        end
        dbus_ack = 1'b0; dbus_rdata = $urandom;
        clear_exp();
        chk_wb = 1; e_wd = 5'd7; e_wreg = ld; chk_wbdata = ld; e_wbdata = x_wb;
        for (int h = 0; h < hold; h++) begin
            stall = 6'b011111;
            dbus_ack = (h == 1);
            tick();
        end
        dbus_ack = 1'b0;
        stall = 6'd0;
        tick();
    endtask

    // Misaligned op kept in the stage for hold+1 cycles; pulse expected in the second cycle
    task automatic misaligned(input logic [7:0] op, input logic [31:0] addr, input int hold);
        mem_aluOp = op; mem_addr = addr; mem_reg2 = 32'hFFFF_FFFF; mem_wd = 5'd12; mem_wreg = 1'b1;
        mem_wdata = 32'h0BAD_0BAD; dbus_ack = 1'b0;
        for (int c = 0; c <= hold; c++) begin
            stall = (c < hold) ? 6'b010000 : 6'd0;
            clear_exp();
            exp_mis = (c == 1);
            chk_wb = 1; e_wd = 5'd12; e_wreg = 1'b0;
            tick();
        end
        mem_aluOp = EXE_NOP_OP; mem_wd = 5'd1; mem_wreg = 1'b0; mem_wdata = 32'h0; stall = 6'd0;
        clear_exp();
        exp_mis = (hold == 0);
        chk_wb = 1; chk_wbdata = 1; e_wd = 5'd1; e_wreg = 1'b0; e_wbdata = 32'h0;
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        mem_aluOp = EXE_LW_OP; mem_addr = 32'h100; mem_reg2 = 32'h1; mem_wd = 5'd9;
        mem_wreg = 1'b1; mem_wdata = 32'hA5A5_A5A5;
        clear_exp();
        tick();
        // Reset state: bus registers zero, combinational outputs pass through
        chk_en = 1'b1;
        chk_bus = 1; chk_sel = 1; chk_bwd = 1; e_we = 0; e_addr = 0; e_sel = 0; e_bwd = 0;
        chk_wb = 1; chk_wbdata = 1; e_wd = 5'd9; e_wreg = 1'b1; e_wbdata = 32'hA5A5_A5A5;
        tick();
        tick();
        rst = 1'b0;

        nonmem(8'h25, 5'd3, 1'b1, 32'h0000_1234, 1'b1);
        nonmem(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 1'b0);

        do_mem(EXE_LW_OP,  32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        do_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h0000_00F0, 0, 0, 4'b0001, 32'h0, 32'hFFFF_FFF0);
        do_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, 0, 4'b0001, 32'h0, 32'h0000_00F0);
        do_mem(EXE_LH_OP,  32'h102, 32'h0, 32'h1234_8001, 1, 0, 4'b0011, 32'h0,
               model_load(EXE_LH_OP, 2'd2, 32'h1234_8001));
        do_mem(EXE_LHU_OP, 32'h100, 32'h0, 32'h8001_5678, 0, 0, 4'b1100, 32'h0,
               model_load(EXE_LHU_OP, 2'd0, 32'h8001_5678));
        do_mem(EXE_LB_OP,  32'h101, 32'h0, 32'h1180_2233, 0, 0, 4'b0100, 32'h0,
               model_load(EXE_LB_OP, 2'd1, 32'h1180_2233));
        do_mem(EXE_SH_OP,  32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 4'b0011, 32'hABCD_ABCD, 32'h0);
        do_mem(EXE_SB_OP,  32'h201, 32'h0000_0077, 32'h0, 0, 0, 4'b0100, 32'h7777_7777, 32'h0);
        do_mem(EXE_SB_OP,  32'h203, 32'h0000_00C3, 32'h0, 1, 0, model_sel(EXE_SB_OP, 2'd3),
               model_store(EXE_SB_OP, 32'h0000_00C3), 32'h0);
        do_mem(EXE_SH_OP,  32'h200, 32'h9999_4321, 32'h0, 0, 0, model_sel(EXE_SH_OP, 2'd0),
               model_store(EXE_SH_OP, 32'h9999_4321), 32'h0);

        misaligned(EXE_LW_OP, 32'h101, 0);
        misaligned(EXE_LH_OP, 32'h203, 3);
        misaligned(EXE_SW_OP, 32'h302, 0);

        do_mem(EXE_SW_OP, 32'h400, 32'hCAFE_F00D, 32'h0, 5, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Reset while an access is outstanding: req withdrawn, unit back in IDLE
        mem_aluOp = EXE_SW_OP; mem_addr = 32'h600; mem_reg2 = 32'h1122_3344; mem_wd = 5'd7;
        mem_wreg = 1'b1; stall = 6'd0; dbus_ack = 1'b0;
        clear_exp(); exp_stall = 1;
        tick();
        clear_exp(); exp_stall = 1; exp_req = 1; chk_bus = 1; chk_sel = 1; chk_bwd = 1;
        e_we = 1; e_addr = 32'h600; e_sel = 4'b1111; e_bwd = 32'h1122_3344;
        tick();
        rst = 1'b1;
        exp_stall = 0;
        tick();
        rst = 1'b0;
        nonmem(EXE_NOP_OP, 5'd4, 1'b1, 32'h4444_0000, 1'b1);
        do_mem(EXE_LW_OP, 32'h700, 32'h0, 32'h7070_7070, 0, 0, 4'b1111, 32'h0, 32'h7070_7070);

        // DONE held by another stall source, then back-to-back loads
        do_mem(EXE_LW_OP, 32'h500, 32'h0, 32'h0102_0304, 0, 3, 4'b1111, 32'h0, 32'h0102_0304);
        do_mem(EXE_LW_OP, 32'h504, 32'h0, 32'hA0B0_C0D0, 1, 0, 4'b1111, 32'h0, 32'hA0B0_C0D0);
        do_mem(EXE_LBU_OP, 32'h506, 32'h0, 32'hA0B0_C0D0, 0, 2, 4'b0010, 32'h0,
               model_load(EXE_LBU_OP, 2'd2, 32'hA0B0_C0D0));
        nonmem(8'h21, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
